// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Desc     : I2S receiver. sclk, lrclk and sdata are oversampled on clk_sys
//            through 2-flop synchronizers. One (lr, data) pair is sampled on
//            each detected sclk rise. WIDTH-bit left/right words are captured
//            MSB first with the standard one-bit I2S delay and presented as a
//            pair with a one-cycle valid strobe.
//            Optional macro I2S_RX_ERR_EN adds a short-slot error strobe and
//            a saturating 8-bit error counter. When the macro is undefined,
//            err and err_cnt are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx #(
  parameter int WIDTH    = 16,
  parameter int CLK_RATE = 96000000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_chan,
  output logic [WIDTH-1:0] right_chan,
  output logic             valid,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [5:0] c_WIDTH   = 6'(WIDTH);
  localparam logic [5:0] c_CNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  // Synchronizer chains and previous-sclk for edge detection
  logic             r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic             r_lr_s1, r_lr_s2;
  logic             r_sd_s1, r_sd_s2;

  state_t           r_state, w_state_next;
  logic [5:0]       r_cnt, w_cnt_inc;
  logic [WIDTH-1:0] r_shift, w_word, r_hold, r_left, r_right;
  logic             r_lr_prev;
  logic             r_valid;

  logic             w_rise;
  logic             w_start_left;
  logic             w_close_left;
  logic             w_close_right;
  logic             w_restart;

  // CLK_RATE is informational only; nothing in the datapath depends on it
  logic             w_unused;
  assign w_unused = (CLK_RATE != 0);

  // Bring the asynchronous I2S pins into the clk_sys domain
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_lr_s1     <= 1'b0;
      r_lr_s2     <= 1'b0;
      r_sd_s1     <= 1'b0;
      r_sd_s2     <= 1'b0;
    end else begin
      r_sclk_s1   <= sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_lr_s1     <= lrclk;
      r_lr_s2     <= r_lr_s1;
      r_sd_s1     <= sdata;
      r_sd_s2     <= r_sd_s1;
    end
  end

  assign w_rise = r_sclk_s2 & ~r_sclk_prev;

  // Bit counter advance; sticks at 63 so long slots never alias short ones
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + 6'd1);

  // Current slot word with the sampled bit dropped into slot position
  // WIDTH-1-cnt; bits past WIDTH match no position and fall away
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_cnt == 6'(WIDTH - 1 - i)) begin
        w_word[i] = r_sd_s2;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and slot boundary decode, evaluated only on sclk rises
  always_comb begin
    w_state_next  = r_state;
    w_start_left  = 1'b0;
    w_close_left  = 1'b0;
    w_close_right = 1'b0;
    if (w_rise) begin
      case (r_state)
        S_SYNC: begin
          if (r_lr_prev && !r_lr_s2) begin
            w_state_next = S_LEFT;
            w_start_left = 1'b1;
          end
        end
        S_LEFT: begin
          if (r_lr_s2) begin
            w_state_next = S_RIGHT;
            w_close_left = 1'b1;
          end
        end
        S_RIGHT: begin
          if (!r_lr_s2) begin
            w_state_next  = S_LEFT;
            w_close_right = 1'b1;
          end
        end
        default: begin
          w_state_next = S_SYNC;
        end
      endcase
    end
  end

  // A fresh slot starts empty, so a short slot closes already zero-filled
  assign w_restart = (r_state == S_SYNC) | w_start_left | w_close_left | w_close_right;

  // Slot assembly, left hold and paired output presentation
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_lr_prev <= 1'b0;
      r_cnt     <= 6'd0;
      r_shift   <= '0;
      r_hold    <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_rise) begin
        r_lr_prev <= r_lr_s2;
        if (w_restart) begin
          r_cnt   <= 6'd0;
          r_shift <= '0;
        end else begin
          r_cnt   <= w_cnt_inc;
          r_shift <= w_word;
        end
        if (w_close_left) begin
          r_hold <= w_word;
        end
        if (w_close_right) begin
          r_left  <= r_hold;
          r_right <= w_word;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign left_chan  = r_left;
  assign right_chan = r_right;
  assign valid      = r_valid;

`ifdef I2S_RX_ERR_EN
  logic       w_short;
  logic       r_err;
  logic [7:0] r_err_cnt;

  // The closing bit is counted first, then the total is compared to WIDTH
  assign w_short = (w_close_left | w_close_right) & (w_cnt_inc < c_WIDTH);

  // Short-slot strobe alongside the slot close; counter saturates at 255
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err <= w_short;
      if (w_short && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  assign err     = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx
// Desc     : Self-checking bench for i2s_rx. Streams of I2S slots are
//            described at slot level (lr, bit count, bits). A slot-level
//            model predicts the left/right pairs and short-slot counts, and
//            a negedge monitor records what the receiver presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

  localparam int W = 16;

  logic         clk_sys = 1'b0;
  logic         reset   = 1'b0;
  logic         sclk    = 1'b0;
  logic         lrclk   = 1'b0;
  logic         sdata   = 1'b0;
  logic [W-1:0] left_chan, right_chan;
  logic         valid, err;
  logic [7:0]   err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor records
  logic [2*W-1:0] got_q[$];
  int             err_seen  = 0;
  int             dbl_valid = 0;
  logic           prev_valid = 1'b0;
  int             g_base, e_base, d_base;

  // Slot list under test and its predicted outcome
  int             s_lr[$];
  int             s_n[$];
  logic [63:0]    s_w[$];
  int             trail;
  logic [2*W-1:0] exp_q[$];
  int             exp_short;

  i2s_rx #(.WIDTH(W), .CLK_RATE(96000000)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid      (valid),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every presented pair and error pulse away from the active edge
  always @(negedge clk_sys) begin
    if (valid) got_q.push_back({left_chan, right_chan});
    if (err) err_seen++;
    if (valid && prev_valid) dbl_valid++;
    prev_valid = valid;
  end

  // Expected captured word: first min(n,W) transmitted bits, MSB first,
  // zero-filled on the right when the slot is short
  function automatic logic [W-1:0] expw(input logic [63:0] bits, input int n);
    logic [63:0] v;
    v = (n >= 64) ? bits : (bits & ((64'd1 << n) - 64'd1));
    if (n >= W) return W'(v >> (n - W));
    else        return W'(v << (W - n));
  endfunction

  task automatic mark();
    g_base = got_q.size();
    e_base = err_seen;
    d_base = dbl_valid;
  endtask

  task automatic clear_list();
    s_lr.delete(); s_n.delete(); s_w.delete();
  endtask

  task automatic add_slot(input int lr, input int n, input logic [63:0] w);
    s_lr.push_back(lr); s_n.push_back(n); s_w.push_back(w);
  endtask

  // Slot-level prediction: lock on the first left slot that follows a right
  // slot in the stream, then every left/right slot pair yields one output
  task automatic compute_expected();
    logic [W-1:0] pend;
    bit           locked;
    exp_q.delete();
    exp_short = 0;
    locked    = 1'b0;
    pend      = '0;
    for (int i = 0; i < s_lr.size(); i++) begin
      if (!locked && i > 0 && s_lr[i] == 0 && s_lr[i-1] == 1) locked = 1'b1;
      if (locked) begin
        if (s_n[i] < W) exp_short++;
        if (s_lr[i] == 0) pend = expw(s_w[i], s_n[i]);
        else exp_q.push_back({pend, expw(s_w[i], s_n[i])});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  // One sclk period (4 clk low, 4 clk high); optionally checks that valid
  // appears on the 3rd clk_sys edge after sclk is first sampled high
  task automatic send_bit(input logic lr, input logic d, input bit chk);
    @(negedge clk_sys);
    sclk = 1'b0; lrclk = lr; sdata = d;
    repeat (4) @(negedge clk_sys);
    sclk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_sys);
      if (chk && i == 2) begin
        n_checks++;
        if (valid !== 1'b0) begin
          n_fail++;
          $display("FAIL latency_early: valid=%b after edge 2, required 0", valid);
        end
      end
      if (chk && i == 3) begin
        n_checks++;
        if (valid !== 1'b1) begin
          n_fail++;
          $display("FAIL latency_edge3: valid=%b after edge 3, required 1", valid);
        end
      end
    end
  endtask

  // Serialize slots with the I2S one-bit delay: a slot's last bit goes out
  // with the following slot's lr value
  task automatic play_slots();
    int   nl;
    logic b;
    bit   chk;
    for (int i = 0; i < s_lr.size(); i++) begin
      for (int j = 0; j < s_n[i]; j++) begin
        nl  = (j == s_n[i] - 1) ? ((i == s_lr.size() - 1) ? trail : s_lr[i+1]) : s_lr[i];
        b   = s_w[i][s_n[i] - 1 - j];
        chk = (i == s_lr.size() - 1) && (j == s_n[i] - 1) && (s_lr[i] == 1) && (exp_q.size() > 0);
        send_bit(nl[0], b, chk);
      end
    end
    @(negedge clk_sys);
    sclk = 1'b0;
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic check_results(input string name);
    int             ngot, nmin, exp_err, exp_ec;
    logic [2*W-1:0] last;
    ngot = got_q.size() - g_base;
    n_checks++;
    if (ngot != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_pair_count: got %0d required %0d", name, ngot, exp_q.size());
    end
    nmin = (ngot < exp_q.size()) ? ngot : exp_q.size();
    for (int k = 0; k < nmin; k++) begin
      n_checks++;
      if (got_q[g_base + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s_pair%0d: got %h required %h", name, k, got_q[g_base + k], exp_q[k]);
      end
    end
    n_checks++;
    if (dbl_valid - d_base != 0) begin
      n_fail++;
      $display("FAIL %s_valid_width: %0d multi-cycle valid strobes, required 0", name, dbl_valid - d_base);
    end
`ifdef I2S_RX_ERR_EN
    exp_err = exp_short;
    exp_ec  = (exp_short > 255) ? 255 : exp_short;
`else
    exp_err = 0;
    exp_ec  = 0;
`endif
    n_checks++;
    if (err_seen - e_base != exp_err) begin
      n_fail++;
      $display("FAIL %s_err_pulses: got %0d required %0d", name, err_seen - e_base, exp_err);
    end
    n_checks++;
    if (err_cnt !== 8'(exp_ec)) begin
      n_fail++;
      $display("FAIL %s_err_cnt: got %0d required %0d", name, err_cnt, exp_ec);
    end
    last = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : '0;
    n_checks++;
    if ({left_chan, right_chan} !== last) begin
      n_fail++;
      $display("FAIL %s_hold: got %h required %h", name, {left_chan, right_chan}, last);
    end
  endtask

  task automatic run_list(input string name);
    do_reset();
    mark();
    compute_expected();
    play_slots();
    check_results(name);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (left_chan !== '0) begin n_fail++; $display("FAIL reset_left: got %h required 0", left_chan); end
    n_checks++;
    if (right_chan !== '0) begin n_fail++; $display("FAIL reset_right: got %h required 0", right_chan); end
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", valid); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_checks++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d required 0", err_cnt); end
  endtask

  task automatic test_basic();
    clear_list();
    add_slot(1, 16, {$urandom, $urandom});
    add_slot(0, 16, 64'hA5C3);
    add_slot(1, 16, 64'h1234);
    trail = 0;
    run_list("basic");
  endtask

  task automatic test_extra_bits();
    clear_list();
    add_slot(1, 24, {$urandom, $urandom});
    add_slot(0, 24, 64'hFFFF00);
    add_slot(1, 24, 64'h8001FF);
    trail = 0;
    run_list("extra_bits");
  endtask

  task automatic test_short();
    clear_list();
    add_slot(1, 16, {$urandom, $urandom});
    add_slot(0, 12, 64'hABC);
    add_slot(1, 12, 64'h123);
    trail = 0;
    run_list("short");
  endtask

  task automatic test_mid_right();
    clear_list();
    add_slot(1, 5, {$urandom, $urandom});
    for (int i = 0; i < 4; i++) add_slot(i % 2, 16, {$urandom, $urandom});
    trail = 0;
    run_list("mid_right");
  endtask

  task automatic test_random();
    int ns, lr;
    for (int it = 0; it < 4; it++) begin
      clear_list();
      ns = $urandom_range(10, 6);
      lr = $urandom_range(1, 0);
      for (int i = 0; i < ns; i++) begin
        add_slot(lr, $urandom_range(40, 4), {$urandom, $urandom});
        lr = 1 - lr;
      end
      trail = lr;
      run_list($sformatf("random%0d", it));
    end
  endtask

  task automatic test_reset_mid();
    clear_list();
    add_slot(1, 16, {$urandom, $urandom});
    add_slot(0, 16, {$urandom, $urandom} | 64'h1);
    add_slot(1, 16, {$urandom, $urandom} | 64'h1);
    trail = 0;
    run_list("pre_reset");
    // seven bits into the new left slot, then reset between clock edges
    for (int k = 0; k < 7; k++) send_bit(1'b0, 1'($urandom), 1'b0);
    @(negedge clk_sys);
    sclk = 1'b0;
    repeat (4) @(negedge clk_sys);
    @(posedge clk_sys);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({left_chan, right_chan} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_data: got %h required 0", {left_chan, right_chan});
    end
    n_checks++;
    if (valid !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset_flags: got valid=%b err=%b cnt=%0d required 0", valid, err, err_cnt);
    end
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    // finish the interrupted slot, then a fresh frame
    mark();
    clear_list();
    add_slot(0, 9, {$urandom, $urandom});
    add_slot(1, 16, {$urandom, $urandom});
    add_slot(0, 16, {$urandom, $urandom});
    add_slot(1, 16, {$urandom, $urandom});
    trail = 0;
    compute_expected();
    play_slots();
    check_results("post_reset");
  endtask

  task automatic test_err_sat();
    clear_list();
    add_slot(1, 4, {$urandom, $urandom});
    for (int i = 0; i < 300; i++) add_slot(i % 2, 4, {$urandom, $urandom});
    trail = 0;
    run_list("err_sat");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extra_bits();
    test_short();
    test_mid_right();
    test_random();
    test_reset_mid();
    test_err_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter WIDTH, default 16, sets the captured sample width per channel; legal range 8..32.
REQ-002 Parameter CLK_RATE, default 96000000, gives the clk_sys frequency in Hz; documentation only, no logic depends on it.
REQ-003 clk_sys  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 sclk  input  1  I2S bit clock, asynchronous to clk_sys.
REQ-006 lrclk  input  1  I2S word select: 0 = left slot, 1 = right slot.
REQ-007 sdata  input  1  I2S serial data, MSB first.
REQ-008 left_chan  output  WIDTH  last complete left sample.
REQ-009 right_chan  output  WIDTH  last complete right sample.
REQ-010 valid  output  1  one-cycle strobe when a new left/right pair is presented.
REQ-011 err  output  1  one-cycle short-slot strobe (see Configuration).
REQ-012 err_cnt  output  8  saturating short-slot count (see Configuration).

Function
REQ-013 sclk, lrclk and sdata shall each pass through a 2-flop synchronizer; an sclk rising edge shall be detected from synchronized-current high and previous low.
REQ-014 sclk high and low phases shall each be at least 2 clk_sys periods; behaviour is undefined below that.
REQ-015 On each detected sclk rise, one (lr, d) pair shall be sampled; no other event advances state.
REQ-016 State machine: SYNC, LEFT, RIGHT. Reset state is SYNC.
REQ-017 SYNC: bits are discarded; a sampled lr 1->0 change shall enter LEFT with bit count 0; a 0->1 change shall stay in SYNC.
REQ-018 I2S one-bit delay: the sample on which lr changes carries the LSB of the previous slot; it shall be appended to the previous slot first, and that slot then closes.
REQ-019 Within a slot, bit index k (0 = MSB) shall be stored at position WIDTH-1-k only when k < WIDTH; later bits are ignored.
REQ-020 The bit counter shall saturate at 63 and shall not wrap.
REQ-021 A slot closing with fewer than WIDTH bits shall have its remaining LSBs zero-filled.
REQ-022 LEFT close (lr 0->1): the left word is latched to an internal hold register, and the state moves to RIGHT.
REQ-023 RIGHT close (lr 1->0): left_chan takes the hold value and right_chan the right word, both in the same cycle; valid pulses for exactly 1 cycle; the state moves to LEFT.
REQ-024 Latency: valid and the output update shall occur on the 3rd clk_sys rising edge after sclk is first sampled high at the pin.
REQ-025 left_chan and right_chan shall hold their values between valid strobes.
REQ-026 A partial pair (right slot not yet closed) shall never produce valid.

Reset
REQ-027 Reset shall clear to 0 immediately, regardless of clk_sys: the synchronizers, state (to SYNC), bit counter, shift and hold registers, left_chan, right_chan, valid, err and err_cnt.
REQ-028 Reset mid-slot shall discard the partial data; after release, no valid occurs before a new lr 1->0 and a full pair.

Configuration
REQ-029 Macro I2S_RX_ERR_EN defined: err pulses 1 cycle, coincident with the slot close, for any slot closing with bit count < WIDTH; err_cnt increments on each err pulse and saturates at 255.
REQ-030 Slot-close detection is ordered: slot bits counted, then count checked against WIDTH, then err raised.
REQ-031 Macro I2S_RX_ERR_EN undefined: err and err_cnt are tied to 0 and no error logic is synthesized; all other behaviour is identical.

Verification
REQ-032 WIDTH=16, 16 sclk/slot, sclk = clk_sys/8, left=0xA5C3, right=0x1234 -> after the second lr 1->0, left_chan=0xA5C3, right_chan=0x1234, valid high 1 cycle, err=0.
REQ-033 24 sclk/slot, left=0xFFFF followed by 8 zero bits, right=0x8001 followed by 8 ones -> left_chan=0xFFFF, right_chan=0x8001; extra bits are ignored.
REQ-034 12-bit slots, left=0xABC, right=0x123, with I2S_RX_ERR_EN defined -> left_chan=0xABC0, right_chan=0x1230, err pulses twice, err_cnt=2.
REQ-035 Stream started mid-right-slot -> the first lr 1->0 produces no valid; the first valid occurs only after one complete left+right pair.
REQ-036 Reset asserted at bit 7 of a left slot, released mid-slot -> all outputs 0; next valid only after a fresh lr 1->0 and a full pair.
REQ-037 300 consecutive short slots with I2S_RX_ERR_EN defined -> err_cnt stops at 255 and does not wrap.
